// File: rtl/deser_sipo.sv
`default_nettype none
// ============================================================================
// Module      : deser_sipo
// Description : Framed serial-in/parallel-out deserializer with a holding
//               register on a valid/ready output port.
// Revision    : 1.0
// ============================================================================
module deser_sipo #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sof,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         ovf,
    output logic         frm_err
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [N-1:0]   r_shift;
    logic [N-1:0]   w_shift_nxt;
    logic           w_frm_err_nxt;
    logic           w_complete;
    logic           w_hold_free;
    logic [N-1:0]   r_dout;
    logic           r_dout_valid;
    logic           r_busy;
    logic           r_ovf;
    logic           r_frm_err;

    // Writes bit b at the position belonging to received-bit index k.
    function automatic logic [N-1:0] f_place(input logic [N-1:0] v,
                                             input int k,
                                             input logic b);
        logic [N-1:0] w_v;
        int           w_idx;
        w_v   = v;
        w_idx = MSB_FIRST ? (N - 1 - k) : k;
        for (int i = 0; i < N; i++) begin
            if (i == w_idx) begin
                w_v[i] = b;
            end
        end
        return w_v;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_frm_err_nxt = 1'b0;
        w_complete    = 1'b0;
        if (sin_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (sof) begin
                        w_shift_nxt = f_place('0, 0, sin);
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sof) begin
                        w_frm_err_nxt = 1'b1;
                        w_shift_nxt   = f_place('0, 0, sin);
                        w_cnt_nxt     = CW'(1);
                    end else begin
                        w_shift_nxt = f_place(r_shift, int'(r_cnt), sin);
                        if (r_cnt == CW'(N - 1)) begin
                            w_complete  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A word taken on this edge frees the holding register for a new one.
    assign w_hold_free = !r_dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_frm_err <= w_frm_err_nxt;
            if (w_complete && w_hold_free) begin
                r_dout       <= w_shift_nxt;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            if (w_complete && !w_hold_free) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign ovf        = r_ovf;
    assign frm_err    = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_deser_sipo.sv
`default_nettype none
// Directed bench for deser_sipo: an MSB-first and an LSB-first instance share
// the same serial stimulus; LSB-first expectations are the bit-reversed words.
module tb_deser_sipo;

    logic       clk = 1'b0;
    logic       clrn;
    logic       sin;
    logic       sin_valid;
    logic       sof;
    logic       dout_ready;
    logic [7:0] dout_m, dout_l;
    logic       dv_m, dv_l, busy_m, busy_l, ovf_m, ovf_l, fe_m, fe_l;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    deser_sipo #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clrn(clrn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .busy(busy_m), .ovf(ovf_m), .frm_err(fe_m)
    );

    deser_sipo #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clrn(clrn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .busy(busy_l), .ovf(ovf_l), .frm_err(fe_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        sof       = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin       = b;
        sof       = s;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Serialises v starting from v[7], sof on the first bit.
    task automatic send_word(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == 7);
    endtask

    initial begin
        logic [7:0] w;
        clrn = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        chk("rst_dout",   32'(dout_m), 32'h00);
        chk("rst_valid",  32'(dv_m),   32'h0);
        chk("rst_busy",   32'(busy_m), 32'h0);
        chk("rst_ovf",    32'(ovf_m),  32'h0);
        chk("rst_frmerr", 32'(fe_m),   32'h0);
        chk("rst_l_dout", 32'(dout_l), 32'h00);

        // Basic word 1,0,1,0,0,1,0,1 back-to-back
        clrn = 1'b1; dout_ready = 1'b1;
        w = 8'hA5;
        send_bit(w[7], 1'b1);
        chk("basic_busy_first",  32'(busy_m), 32'h1);
        chk("basic_valid_first", 32'(dv_m),   32'h0);
        for (int i = 6; i >= 1; i--) send_bit(w[i], 1'b0);
        chk("basic_busy_7th",  32'(busy_m), 32'h1);
        chk("basic_valid_7th", 32'(dv_m),   32'h0);
        send_bit(w[0], 1'b0);
        chk("basic_dout",    32'(dout_m), 32'hA5);
        chk("basic_valid",   32'(dv_m),   32'h1);
        chk("basic_busy_end",32'(busy_m), 32'h0);
        chk("basic_l_dout",  32'(dout_l), 32'hA5);
        idle(1);
        chk("basic_valid_drop", 32'(dv_m),   32'h0);
        chk("basic_dout_keep",  32'(dout_m), 32'hA5);

        // Same bits with two stall cycles between valid bits
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], i == 7);
            if (i != 0) begin
                idle(2);
                if (i == 4) begin
                    chk("stall_busy",  32'(busy_l), 32'h1);
                    chk("stall_valid", 32'(dv_l),   32'h0);
                end
            end
        end
        chk("stall_l_dout",  32'(dout_l), 32'hA5);
        chk("stall_l_valid", 32'(dv_l),   32'h1);
        idle(1);

        // Non-sof bits while idle are ignored
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        chk("idle_ign_busy",  32'(busy_m), 32'h0);
        chk("idle_ign_valid", 32'(dv_m),   32'h0);

        // Back-pressure and overflow
        dout_ready = 1'b0;
        send_word(8'h3C);
        chk("bp_dout",  32'(dout_m), 32'h3C);
        chk("bp_valid", 32'(dv_m),   32'h1);
        chk("bp_ovf0",  32'(ovf_m),  32'h0);
        send_word(8'hC3);
        chk("ovf_dout",   32'(dout_m), 32'h3C);
        chk("ovf_l_dout", 32'(dout_l), 32'h3C);
        chk("ovf_valid",  32'(dv_m),   32'h1);
        chk("ovf_flag",   32'(ovf_m),  32'h1);
        dout_ready = 1'b1;
        idle(1);
        chk("ovf_take_valid", 32'(dv_m),  32'h0);
        chk("ovf_sticky",     32'(ovf_m), 32'h1);
        idle(2);
        chk("ovf_sticky2",    32'(ovf_l), 32'h1);

        // Reset with a held word and a partial word
        dout_ready = 1'b0;
        send_word(8'h11);
        w = 8'h96;
        for (int i = 7; i >= 3; i--) send_bit(w[i], i == 7);
        clrn = 1'b0;
        tick();
        chk("mrst_dout",  32'(dout_m), 32'h00);
        chk("mrst_valid", 32'(dv_m),   32'h0);
        chk("mrst_busy",  32'(busy_m), 32'h0);
        chk("mrst_ovf",   32'(ovf_m),  32'h0);
        chk("mrst_fe",    32'(fe_m),   32'h0);
        clrn = 1'b1; dout_ready = 1'b1;
        send_word(8'hFF);
        chk("mrst_ff_dout",  32'(dout_m), 32'hFF);
        chk("mrst_ff_valid", 32'(dv_m),   32'h1);
        idle(1);

        // Take on the same edge as the next completion
        dout_ready = 1'b0;
        send_word(8'h11);
        chk("sim_hold",   32'(dout_m), 32'h11);
        chk("sim_l_hold", 32'(dout_l), 32'h88);
        w = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
        dout_ready = 1'b1;
        send_bit(w[0], 1'b0);
        chk("sim_dout",   32'(dout_m), 32'h22);
        chk("sim_l_dout", 32'(dout_l), 32'h44);
        chk("sim_valid",  32'(dv_m),   32'h1);
        chk("sim_ovf",    32'(ovf_m),  32'h0);
        idle(1);
        chk("sim_drop",   32'(dv_m),   32'h0);

        // Resync: 4 partial bits, then a full frame starting with sof
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        chk("rs_fe_before", 32'(fe_m), 32'h0);
        w = 8'h5A;
        send_bit(w[7], 1'b1);
        chk("rs_fe",      32'(fe_m),   32'h1);
        chk("rs_l_fe",    32'(fe_l),   32'h1);
        chk("rs_busy",    32'(busy_m), 32'h1);
        send_bit(w[6], 1'b0);
        chk("rs_fe_drop", 32'(fe_m),   32'h0);
        for (int i = 5; i >= 0; i--) send_bit(w[i], 1'b0);
        chk("rs_dout",   32'(dout_m), 32'h5A);
        chk("rs_l_dout", 32'(dout_l), 32'h5A);
        chk("rs_valid",  32'(dv_m),   32'h1);
        chk("rs_ovf",    32'(ovf_m),  32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deser_sipo.md
Name: deser_sipo

Overview:
- Serial-in/parallel-out deserializer. It is the receive end of the bit-serial link produced by a counter-driven mux select (parallel-to-serial).
- Collects N framed serial bits into a word and presents the word on a valid/ready output port.
- A holding register lets the next word shift in while the current word waits to be taken.
- Sits between the serial link and word-wide datapath logic.

Parameters:
- N, 8, bits per word (legal range 2..32).
- MSB_FIRST, 1. 1: first received bit lands in dout[N-1]. 0: first received bit lands in dout[0].

Ports:
- clk, input, 1, rising-edge clock.
- clrn, input, 1, synchronous active-low reset; sampled on the rising edge of clk.
- sin, input, 1, serial data bit.
- sin_valid, input, 1, sin is valid this cycle.
- sof, input, 1, start-of-frame; qualified by sin_valid; marks the first bit of a word.
- dout, output, N, assembled word (holding register).
- dout_valid, output, 1, dout holds an untaken word.
- dout_ready, input, 1, consumer accepts dout this cycle.
- busy, output, 1, a partial word is being shifted.
- ovf, output, 1, sticky overflow; a completed word was dropped.
- frm_err, output, 1, one-cycle pulse; a partial word was aborted by sof.

Behaviour:
- Reset (clrn=0 at an edge):
  - state=IDLE; bit counter=0; shift register=0.
  - dout=0, dout_valid=0, busy=0, ovf=0, frm_err=0.
  - Reset mid-word discards the partial word and any held word. No output pulse.
- Only edges with sin_valid=1 advance the shifter. sin_valid=0 stalls with no state change.
- Default: frm_err=0 each cycle unless set below.
- State IDLE (busy=0):
  - sin_valid&sof: capture sin as bit 0, count=1, go SHIFT.
  - sin_valid&!sof: bit is discarded; stay IDLE.
- State SHIFT (busy=1):
  - sin_valid&!sof: capture bit at position count; count+1.
  - sin_valid&sof: resync. Abort the partial word, frm_err=1 for one cycle, capture sin as new bit 0, count=1, stay SHIFT.
- Bit placement:
  - MSB_FIRST=1: bit k goes to position N-1-k.
  - MSB_FIRST=0: bit k goes to position k.
- Word completion: the edge that captures bit N-1 (non-sof) completes the word.
  - Go IDLE, count=0, busy=0 after that edge.
  - If the holding register is free, dout=assembled word and dout_valid=1 after that same edge.
  - Latency: last bit sampled at edge E, dout_valid high immediately after E.
  - N=2 edge case: a sof bit followed by one non-sof bit completes the word.
- Holding register is free when dout_valid=0, or when dout_valid&dout_ready at the same edge.
- Output handshake:
  - Transfer occurs at an edge with dout_valid&dout_ready.
  - Transfer with no simultaneous completion: dout_valid=0 next cycle; dout keeps its last value.
  - Transfer with simultaneous completion: the new word loads, dout_valid stays 1, no overflow.
- Overflow: completion while dout_valid=1 and dout_ready=0.
  - The completed word is dropped; dout and dout_valid are unchanged.
  - ovf=1 and stays 1 until reset.
- dout, dout_valid, busy, ovf and frm_err are all registered. There are no combinational paths from inputs to outputs.
- The counter is wide enough for 0..N.
- Implementation is fully synchronous with no latches and no tristates.

Test Plan:
- Basic MSB-first word, N=8:
  - Stimulus: after reset, send 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sof on the first, dout_ready=1.
  - Response: dout=8'hA5 and dout_valid=1 for exactly one cycle, right after the 8th edge; busy high for 7 cycles after the first edge.
- Stalls and LSB-first:
  - Stimulus: MSB_FIRST=0, same bit sequence with sin_valid=0 gaps of 2 cycles between bits.
  - Response: dout=8'hA5; no change during gaps; dout_valid only after the 8th valid bit.
- Back-pressure and overflow:
  - Stimulus: dout_ready=0; send word 8'h3C, then word 8'hC3.
  - Response: dout stays 8'h3C, ovf=1 after 8'hC3 completes, 8'hC3 lost.
  - Then dout_ready=1: dout_valid drops, ovf stays 1.
- Simultaneous take and complete:
  - Stimulus: hold 8'h11; assert dout_ready on the same edge as the last bit of 8'h22.
  - Response: dout=8'h22, dout_valid stays 1, ovf=0.
- Resync:
  - Stimulus: send 4 bits, then sof with the 8 bits of 8'h5A.
  - Response: frm_err=1 for one cycle after the sof edge; output word is 8'h5A.
  - Also: bits with sof=0 while IDLE are ignored.
- Reset mid-operation:
  - Stimulus: clrn=0 for one edge after 5 bits, with a word held.
  - Response: all outputs 0 next cycle.
  - A following full frame 8'hFF is received correctly.
